fifo_uart_transmitter: RTL and testbench

FIFO_UART_TRANSMITTER -- requirements
Module: fifo_uart_transmitter

---
 rtl/fifo_uart_transmitter.sv | 153 +++++++++++++++
 tb/tb_fifo_uart_transmitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_transmitter.sv
// fifo_uart_transmitter: drains bytes from an upstream FIFO and sends each one
// as an 8N1 UART frame (LSB first, idle high). One byte costs IDLE + READ +
// LOAD + 10 bit periods, and the next byte can start after one IDLE cycle.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   enable     - allows a new FIFO read from IDLE; a frame in flight always completes
//   fifo_empty - upstream empty flag, looked at only in IDLE
//   fifo_dout  - upstream read data, valid the cycle after fifo_rd_en
//   fifo_rd_en - one-cycle read strobe (READ state)
//   tx         - registered serial output
//   busy       - high in every state except IDLE
//   byte_done  - one-cycle pulse on the last cycle of the stop bit
module fifo_uart_transmitter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        bit_end;
  logic        tx_nxt;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, Moore outputs and the next value of the registered tx line
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    byte_done  = 1'b0;
    tx_nxt     = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable && !fifo_empty) begin
          state_nxt = READ;
        end
      end
      READ: begin
        fifo_rd_en = 1'b1;
        state_nxt  = LOAD;
      end
      LOAD: begin
        state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          byte_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // tx is registered, so it is set up from where the FSM is heading.
    // Inside DATA the bit after the current one is shift_reg[1], because the
    // shift register moves right on the same edge.
    case (state_nxt)
      START: tx_nxt = 1'b0;
      DATA: begin
        if (state == START) begin
          tx_nxt = shift_reg[0];
        end else if (bit_end) begin
          tx_nxt = shift_reg[1];
        end else begin
          tx_nxt = tx;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  // Baud counter, bit index, shift register and serial line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      tx        <= 1'b1;
    end else begin
      tx <= tx_nxt;

      // The counter only runs inside a frame and restarts on every bit
      // boundary and on every state change.
      if ((state_nxt != state) || bit_end ||
          !(state inside {START, DATA, STOP})) begin
        baud_cnt <= 16'd0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      if (state == DATA) begin
        if (bit_end) begin
          bit_idx   <= bit_idx + 3'd1;
          shift_reg <= {1'b0, shift_reg[7:1]};
        end
      end else begin
        bit_idx <= 3'd0;
      end

      if (state == LOAD) begin
        shift_reg <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_transmitter.sv
// Bench for fifo_uart_transmitter with CLKS_PER_BIT = 4.
// A bench-side FIFO feeds the DUT. A frame model works out every output from
// "cycles since READ" and the popped byte. Directed scenarios add literal checks.
module tb_fifo_uart_transmitter;

  localparam int CPB   = 4;
  localparam int FRAME = 2 + 10 * CPB;   // READ, LOAD, then ten bit periods

  logic       clk;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       byte_done;

  fifo_uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side FIFO, plus overrides used to disturb the DUT mid-frame
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] dout_reg = 8'h00;
  logic       pend = 1'b0;
  logic       empty_force = 1'b0;
  logic       empty_val = 1'b0;
  logic       corrupt = 1'b0;
  logic [7:0] corrupt_val = 8'h00;

  assign fifo_empty = empty_force ? empty_val : (wr_ptr == rd_ptr);
  assign fifo_dout  = corrupt ? corrupt_val : dout_reg;

  // Frame model: k = cycles since READ (-1 when idle), mb = byte being sent
  int         k = -1;
  logic [7:0] mb = 8'h00;

  // Bookkeeping and counters
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   rd_cyc = -1000;
  int   done_cyc = -1000;
  int   rd_hist [0:7];
  logic txlog [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected {tx, fifo_rd_en, busy, byte_done} for a given frame position
  function automatic logic [3:0] model_out(input int kk, input logic [7:0] b);
    logic t;
    int   bi;
    if (kk < 0) return 4'b1000;
    if (kk < 2) begin
      t = 1'b1;
    end else begin
      bi = (kk - 2) / CPB;
      if (bi == 0)      t = 1'b0;
      else if (bi <= 8) t = b[bi-1];
      else              t = 1'b1;
    end
    return {t, (kk == 0), 1'b1, (kk == FRAME - 1)};
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic clear_stats();
    rd_cnt   = 0;
    done_cnt = 0;
    rd_cyc   = -1000;
    done_cyc = -1000;
  endtask

  // One clock cycle: compare and log at negedge, advance the model at posedge,
  // then let the FIFO answer a sampled read just after the edge.
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    e = model_out(reset ? k : -1, mb);
    chk("tx",        {31'd0, tx},         {31'd0, e[3]});
    chk("rd_en",     {31'd0, fifo_rd_en}, {31'd0, e[2]});
    chk("busy",      {31'd0, busy},       {31'd0, e[1]});
    chk("byte_done", {31'd0, byte_done},  {31'd0, e[0]});
    if (fifo_rd_en) begin
      if (rd_cnt < 8) rd_hist[rd_cnt] = cyc;
      rd_cnt++;
      rd_cyc = cyc;
      pend   = 1'b1;
    end
    if (byte_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((cyc - rd_cyc) >= 0 && (cyc - rd_cyc) < 64) txlog[cyc - rd_cyc] = tx;

    @(posedge clk);
    if (!reset) begin
      k = -1;
    end else if (k < 0) begin
      if (enable && !fifo_empty) begin
        k  = 0;
        mb = mem[rd_ptr];
      end
    end else if (k == FRAME - 1) begin
      k = -1;
    end else begin
      k++;
    end
    #1;
    if (pend) begin
      dout_reg = mem[rd_ptr];
      rd_ptr++;
      pend = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // 0xA5 framed LSB first: start 0, data 1,0,1,0,0,1,0,1, stop 1 (bit 0 first here)
  logic [9:0] a5_bits;
  int         en_cyc;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    a5_bits = 10'b1101001010;
    #1 reset = 1'b0;

    // Reset state
    run(3);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Byte waiting but enable low: nothing happens for 100 cycles
    push(8'hA5);
    run(100);
    chk("noen_rd_cnt", rd_cnt, 0);
    chk("noen_tx", {31'd0, tx}, 32'd1);

    // Raise enable: READ in the very next cycle, then the 0xA5 frame
    clear_stats();
    en_cyc = cyc;
    enable = 1'b1;
    run(50);
    chk("en_to_read", rd_cyc - en_cyc, 1);
    chk("a5_rd_cnt", rd_cnt, 1);
    chk("a5_done_cnt", done_cnt, 1);
    // Last stop cycle is 41 cycles after READ: the 43rd cycle counting IDLE
    chk("a5_done_at", done_cyc - rd_cyc, 41);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d", i), {31'd0, txlog[2 + CPB*i + CPB/2]}, {31'd0, a5_bits[i]});
    end
    chk("a5_busy_end", {31'd0, busy}, 32'd0);

    // Back-to-back 0x00 and 0xFF: one IDLE cycle between STOP and READ
    clear_stats();
    push(8'h00);
    push(8'hFF);
    run(100);
    chk("b2b_rd_cnt", rd_cnt, 2);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_gap", rd_hist[1] - rd_hist[0], FRAME + 1);

    // Enable dropped in the middle of DATA for 0x3C
    clear_stats();
    push(8'h3C);
    run(20);
    enable = 1'b0;
    push(8'h55);
    run(80);
    chk("endrop_rd_cnt", rd_cnt, 1);
    chk("endrop_done_cnt", done_cnt, 1);
    chk("endrop_busy", {31'd0, busy}, 32'd0);

    // Re-enable: the waiting 0x55 goes out
    clear_stats();
    enable = 1'b1;
    run(50);
    chk("reen_rd_cnt", rd_cnt, 1);
    chk("reen_done_cnt", done_cnt, 1);

    // Reset during data bit 3 of 0x81 (a 0 bit): line goes high at once
    clear_stats();
    push(8'h81);
    push(8'h7E);
    run(20);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async_tx", {31'd0, tx}, 32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, byte_done}, 32'd0);
    run(3);
    reset = 1'b1;
    run(60);
    chk("rst_rd_cnt", rd_cnt, 2);
    chk("rst_done_cnt", done_cnt, 1);
    chk("rst_done_at", done_cyc - rd_cyc, 41);

    // fifo_empty toggling and fifo_dout churning after LOAD of 0x96
    clear_stats();
    push(8'h96);
    run(3);
    for (int i = 0; i < 35; i++) begin
      empty_force = 1'b1;
      empty_val   = i[0];
      corrupt     = 1'b1;
      corrupt_val = 8'($urandom);
      tick();
    end
    empty_force = 1'b0;
    corrupt     = 1'b0;
    run(20);
    chk("noise_rd_cnt", rd_cnt, 1);
    chk("noise_done_cnt", done_cnt, 1);

    // Enabled but FIFO empty: no read strobe
    clear_stats();
    run(20);
    chk("empty_rd_cnt", rd_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
